des_block_engine: RTL and testbench
===================================

# des_block_engine

Parametrised block-cipher sequencer for the DES datapath. It sits between the PipeIn-fed input block RAM, the iterative DES core and the PipeOut-drained output block RAM, all on okClk. It processes a host-programmed number of 64-bit blocks in ECB or CBC mode, encrypting or decrypting. It reports progress, supports abort, and rejects illegal lengths.

## Interface
Parameters:
- ADDR_W, 9: RAM word-address width (32-bit words). Maximum block count is MAXB = 2^(ADDR_W-1).

Ports:
- okClk  in  1  the only clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle trigger; sampled only in IDLE.
- abort  in  1  level; stops the run at the next edge.
- decrypt  in  1  0 = encrypt, 1 = decrypt; latched when start is accepted.
- cbc_en  in  1  0 = ECB, 1 = CBC; latched when start is accepted.
- iv  in  64  CBC initial vector; latched when start is accepted.
- num_blocks  in  ADDR_W  block count; legal range is 1..MAXB; latched when start is accepted.
- rd_addr  out  ADDR_W  input-RAM read address (1-cycle read latency).
- rd_data  in  32  input-RAM read data.
- wr_en  out  1  output-RAM write strobe.
- wr_addr  out  ADDR_W  output-RAM write address.
- wr_data  out  32  output-RAM write data.
- core_in  out  64  DES core input block.
- core_round  out  4  DES core round select.
- core_decrypt  out  1  DES core direction.
- core_out  in  64  DES core result.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse on normal completion.
- error  out  1  one-cycle pulse when start is rejected.
- blocks_done  out  ADDR_W  count of blocks written in the current or last run.

## Operation
- Word order: block k low word is at address 2k and high word is at 2k+1, for both RAMs.
- States: IDLE, LOAD0, LOAD1, LOAD2, ROUND, WR0, WR1, DONE.
- IDLE:
  - start with num_blocks in 1..MAXB: latch decrypt, cbc_en, iv, num_blocks; set chain = iv; clear blocks_done; go to LOAD0.
  - start with num_blocks of 0 or greater than MAXB: error = 1 for the next cycle only; state stays IDLE.
- LOAD0: rd_addr = 2k.
- LOAD1: rd_addr = 2k+1; capture low = rd_data.
- LOAD2: capture high = rd_data; set blk = {high, low}.
  - core_in = blk XOR chain when cbc_en and encrypting, otherwise blk.
  - core_round = 0.
- ROUND: core_round increments once per cycle, 0..15. On the edge where core_round == 15, capture the result:
  - ECB: result = core_out.
  - CBC encrypt: result = core_out; chain = core_out.
  - CBC decrypt: result = core_out XOR chain; chain = blk.
- WR0: wr_en = 1, wr_addr = 2k, wr_data = result[31:0].
- WR1: wr_en = 1, wr_addr = 2k+1, wr_data = result[63:32]; blocks_done increments.
  - Go to DONE if blocks_done + 1 == num_blocks, otherwise go to LOAD0 with k+1.
- DONE: done = 1; go to IDLE.
- Address arithmetic is ADDR_W bits. When num_blocks == MAXB, the last high word is at 2^ADDR_W - 1; the address never wraps during a legal run.
- start while busy is ignored.
- abort in any non-IDLE state: go to IDLE at the next edge. No done pulse, no further wr_en, blocks_done holds. abort takes priority over every other transition, including the DONE transition.
- Input ports are sampled only at start acceptance, so changing them mid-run has no effect.

## Timing
- All outputs are registered. Reset value of every output is 0, and state resets to IDLE; reset overrides abort and start. Reset mid-run is equivalent to abort, and in addition clears blocks_done and chain.
- Cycle numbering: start is sampled high at cycle 0.
  - Block k occupies cycles 21k+1 (LOAD0) through 21k+21 (WR1).
  - ROUND covers cycles 21k+4..21k+19.
- DONE is in cycle 21N+1, where done = 1. busy is high for cycles 1..21N+1.
- An error pulse appears in cycle 1; busy never rises.
- A new start is accepted in cycle 21N+2 at the earliest.
- core_decrypt is held constant for the whole run.

## Test plan
- ECB encrypt, key 133457799BBCDFF1, N=1, words 89ABCDEF and 01234567 → wr addr0 = 0F0AB405, addr1 = 85E81354; done in cycle 22; blocks_done = 1.
- ECB decrypt of that result → 89ABCDEF and 01234567 written back; done in cycle 22.
- CBC encrypt, N=3, iv = 0123456789ABCDEF → output matches a software DES-CBC model. Feed that output through a CBC decrypt run → the original plaintext is recovered; core_decrypt is stable throughout.
- num_blocks = 0, then num_blocks = 257 (ADDR_W = 9) → error pulses in cycle 1, busy stays 0, no wr_en.
- N=4, abort in cycle 30 → busy = 0 in cycle 31, blocks_done = 1, no done, no writes after cycle 21. Separately, reset in cycle 25 → all outputs 0 in cycle 26.
- N=256 full depth → last write to address 511 in cycle 5376, done in cycle 5377. A start issued in cycle 100 is ignored.

Source files
------------

// File: rtl/des_block_engine.sv
// des_block_engine
// Sequences a host-programmed number of 64-bit blocks through an iterative
// DES core in ECB or CBC mode, encrypting or decrypting. Blocks are read
// from the input block RAM, which has a one-cycle read latency, and results
// go to the output block RAM. In both RAMs, block k holds its low word at
// address 2k and its high word at 2k+1. Every output is a register.
//
// Ports
//   okClk        clock; all logic runs on its rising edge
//   reset        synchronous, active-high
//   start        one-cycle trigger, sampled only while idle
//   abort        level; returns to idle at the next edge
//   decrypt      0 = encrypt, 1 = decrypt (latched at start)
//   cbc_en       0 = ECB, 1 = CBC (latched at start)
//   iv           CBC initial vector (latched at start)
//   num_blocks   block count, legal range 1..2^(ADDR_W-1) (latched at start)
//   rd_addr      input RAM read address
//   rd_data      input RAM read data
//   wr_en        output RAM write strobe
//   wr_addr      output RAM write address
//   wr_data      output RAM write data
//   core_in      DES core input block
//   core_round   DES core round select
//   core_decrypt DES core direction, held for the whole run
//   core_out     DES core result
//   busy         high in every state except idle
//   done         one-cycle pulse on normal completion
//   error        one-cycle pulse when start is rejected
//   blocks_done  number of blocks written in the current or last run
module des_block_engine #(
    parameter int ADDR_W = 9
) (
    input  logic              okClk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              decrypt,
    input  logic              cbc_en,
    input  logic [63:0]       iv,
    input  logic [ADDR_W-1:0] num_blocks,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [63:0]       core_in,
    output logic [3:0]        core_round,
    output logic              core_decrypt,
    input  logic [63:0]       core_out,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] blocks_done
);

    localparam logic [ADDR_W-1:0] MAXB   = {1'b1, {(ADDR_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-2:0] ONE_K  = {{(ADDR_W-2){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD0 = 3'd1,
        S_LOAD1 = 3'd2,
        S_LOAD2 = 3'd3,
        S_ROUND = 3'd4,
        S_WR0   = 3'd5,
        S_WR1   = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t            state_r;
    logic              dec_r;
    logic              cbc_r;
    logic [ADDR_W-1:0] nblk_r;
    logic [ADDR_W-2:0] idx_r;        // current block index k
    logic [63:0]       chain_r;
    logic [63:0]       blk_r;        // raw input block, next CBC-decrypt chain
    logic [31:0]       low_r;
    logic [31:0]       result_hi_r;  // high result word, written in WR1

    logic              legal_s;
    logic              last_s;
    logic [63:0]       blk_s;
    logic [63:0]       core_in_s;
    logic [63:0]       result_s;
    logic [ADDR_W-2:0] idx_next_s;

    // Length check, chaining XORs and last-block detection
    always_comb begin
        legal_s    = 1'b0;
        last_s     = 1'b0;
        blk_s      = {rd_data, low_r};
        core_in_s  = blk_s;
        result_s   = core_out;
        idx_next_s = idx_r + ONE_K;
        if ((num_blocks != ZERO_A) && (num_blocks <= MAXB)) begin
            legal_s = 1'b1;
        end else begin
            legal_s = 1'b0;
        end
        // CBC encryption whitens the plaintext before it enters the core
        if (cbc_r && !dec_r) begin
            core_in_s = blk_s ^ chain_r;
        end else begin
            core_in_s = blk_s;
        end
        // CBC decryption removes the chain from the core output
        if (cbc_r && dec_r) begin
            result_s = core_out ^ chain_r;
        end else begin
            result_s = core_out;
        end
        if ((blocks_done + ONE_A) == nblk_r) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge okClk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            dec_r        <= 1'b0;
            cbc_r        <= 1'b0;
            nblk_r       <= ZERO_A;
            idx_r        <= {(ADDR_W-1){1'b0}};
            chain_r      <= 64'd0;
            blk_r        <= 64'd0;
            low_r        <= 32'd0;
            result_hi_r  <= 32'd0;
            rd_addr      <= ZERO_A;
            wr_en        <= 1'b0;
            wr_addr      <= ZERO_A;
            wr_data      <= 32'd0;
            core_in      <= 64'd0;
            core_round   <= 4'd0;
            core_decrypt <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            blocks_done  <= ZERO_A;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            wr_en <= 1'b0;
            // Abort beats every other transition, including DONE -> IDLE
            if (abort && (state_r != S_IDLE)) begin
                state_r <= S_IDLE;
                busy    <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (start) begin
                            if (legal_s) begin
                                dec_r        <= decrypt;
                                cbc_r        <= cbc_en;
                                nblk_r       <= num_blocks;
                                chain_r      <= iv;
                                idx_r        <= {(ADDR_W-1){1'b0}};
                                blocks_done  <= ZERO_A;
                                rd_addr      <= ZERO_A;
                                core_decrypt <= decrypt;
                                busy         <= 1'b1;
                                state_r      <= S_LOAD0;
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    S_LOAD0: begin
                        rd_addr <= {idx_r, 1'b1};
                        state_r <= S_LOAD1;
                    end
                    S_LOAD1: begin
                        // rd_data now carries the low word requested in LOAD0
                        low_r   <= rd_data;
                        state_r <= S_LOAD2;
                    end
                    S_LOAD2: begin
                        blk_r      <= blk_s;
                        core_in    <= core_in_s;
                        core_round <= 4'd0;
                        state_r    <= S_ROUND;
                    end
                    S_ROUND: begin
                        if (core_round == 4'd15) begin
                            wr_en       <= 1'b1;
                            wr_addr     <= {idx_r, 1'b0};
                            wr_data     <= result_s[31:0];
                            result_hi_r <= result_s[63:32];
                            if (cbc_r) begin
                                chain_r <= dec_r ? blk_r : core_out;
                            end
                            state_r <= S_WR0;
                        end else begin
                            core_round <= core_round + 4'd1;
                        end
                    end
                    S_WR0: begin
                        wr_en   <= 1'b1;
                        wr_addr <= {idx_r, 1'b1};
                        wr_data <= result_hi_r;
                        state_r <= S_WR1;
                    end
                    S_WR1: begin
                        blocks_done <= blocks_done + ONE_A;
                        if (last_s) begin
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            idx_r   <= idx_next_s;
                            rd_addr <= {idx_next_s, 1'b0};
                            state_r <= S_LOAD0;
                        end
                    end
                    S_DONE: begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                    default: begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_des_block_engine.sv
// Testbench for des_block_engine: directed sequence of randomized runs
// compared against a block-level ECB/CBC reference model.
module tb_des_block_engine;

    localparam int AW = 9;
    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] K2 = 64'h0F1E2D3C4B5A6978;
    localparam logic [63:0] IV_FIXED = 64'h0123456789ABCDEF;

    logic          ok_clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic          decrypt;
    logic          cbc_en;
    logic [63:0]   iv;
    logic [AW-1:0] num_blocks;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [63:0]   core_in;
    logic [3:0]    core_round;
    logic          core_decrypt;
    logic [63:0]   core_out;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] blocks_done;

    des_block_engine #(.ADDR_W(AW)) dut (
        .okClk(ok_clk), .reset(reset), .start(start), .abort(abort),
        .decrypt(decrypt), .cbc_en(cbc_en), .iv(iv), .num_blocks(num_blocks),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .core_in(core_in), .core_round(core_round),
        .core_decrypt(core_decrypt), .core_out(core_out), .busy(busy),
        .done(done), .error(error), .blocks_done(blocks_done)
    );

    initial ok_clk = 1'b0;
    always #5 ok_clk = ~ok_clk;

    // Reversible 64-bit mix standing in for the keyed DES permutation
    function automatic logic [63:0] enc_f(input logic [63:0] x);
        logic [63:0] t;
        t = (x ^ K1) + K2;
        return {t[46:0], t[63:47]};
    endfunction

    function automatic logic [63:0] dec_f(input logic [63:0] y);
        logic [63:0] t;
        t = {y[16:0], y[63:17]};
        return (t - K2) ^ K1;
    endfunction

    function automatic logic [63:0] core_f(input logic [63:0] x, input logic d);
        return d ? dec_f(x) : enc_f(x);
    endfunction

    // Core result is only meaningful in the final round
    assign core_out = (core_round == 4'd15) ? core_f(core_in, core_decrypt)
                                            : ~core_f(core_in, core_decrypt);

    logic [31:0] in_mem  [0:511];
    logic [31:0] out_mem [0:511];
    int          wr_cyc_a[0:511];
    logic [63:0] exp_blk [0:255];
    logic [63:0] orig_blk[0:255];

    // Input RAM with one-cycle read latency
    always @(posedge ok_clk) rd_data <= in_mem[rd_addr];

    int cyc = 0;
    // Free-running cycle counter
    always @(posedge ok_clk) cyc <= cyc + 1;

    int   t0, rel;
    int   wr_cnt, last_wr_cyc, last_wr_addr;
    int   done_cnt, done_cyc, err_cnt, err_cyc, busy_cnt, busy_last, dec_bad;
    logic exp_dec;
    int   passed = 0;
    int   total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic clear_log();
        for (int i = 0; i < 512; i++) begin
            out_mem[i]  = 32'd0;
            wr_cyc_a[i] = -1;
        end
        wr_cnt = 0; last_wr_cyc = -1; last_wr_addr = -1;
        done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
        busy_cnt = 0; busy_last = -1; dec_bad = 0;
    endtask

    // Advance one cycle, observe outputs mid-cycle, scramble idle inputs
    task automatic tick();
        @(negedge ok_clk);
        rel = cyc - t0;
        if (wr_en === 1'b1) begin
            wr_cnt++;
            last_wr_cyc  = rel;
            last_wr_addr = int'(wr_addr);
            out_mem[wr_addr]  = wr_data;
            wr_cyc_a[wr_addr] = rel;
        end
        if (done === 1'b1) begin done_cnt++; done_cyc = rel; end
        if (error === 1'b1) begin err_cnt++; err_cyc = rel; end
        if (busy === 1'b1) begin
            busy_cnt++;
            busy_last = rel;
            if (core_decrypt !== exp_dec) dec_bad++;
        end
        if (start == 1'b0) begin
            decrypt    = 1'($urandom);
            cbc_en     = 1'($urandom);
            iv         = {$urandom, $urandom};
            num_blocks = AW'($urandom);
        end
    endtask

    task automatic launch(input int n, input logic dec, input logic cbc, input logic [63:0] ivv);
        clear_log();
        num_blocks = n[AW-1:0];
        decrypt    = dec;
        cbc_en     = cbc;
        iv         = ivv;
        exp_dec    = dec;
        t0         = cyc;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic run_to(input int target);
        while ((cyc - t0) < target) tick();
    endtask

    // Block-level ECB/CBC reference over the input RAM contents
    task automatic model(input int n, input logic dec, input logic cbc, input logic [63:0] ivv);
        logic [63:0] prev, p;
        prev = ivv;
        for (int k = 0; k < n; k++) begin
            p = {in_mem[2*k+1], in_mem[2*k]};
            if (!cbc) begin
                exp_blk[k] = dec ? dec_f(p) : enc_f(p);
            end else if (!dec) begin
                exp_blk[k] = enc_f(p ^ prev);
                prev = exp_blk[k];
            end else begin
                exp_blk[k] = dec_f(p) ^ prev;
                prev = p;
            end
        end
    endtask

    task automatic check_run(input int n);
        check("done_count", done_cnt, 1);
        check("done_cycle", done_cyc, 21*n+1);
        check("wr_count", wr_cnt, 2*n);
        check("last_wr_cycle", last_wr_cyc, 21*n);
        check("last_wr_addr", last_wr_addr, 2*n-1);
        check("busy_cycles", busy_cnt, 21*n+1);
        check("busy_last", busy_last, 21*n+1);
        check("blocks_done", blocks_done, n);
        check("core_decrypt_stable", dec_bad, 0);
        for (int k = 0; k < n; k++) begin
            check("data", {out_mem[2*k+1], out_mem[2*k]}, exp_blk[k]);
            check("wr_cycle", {wr_cyc_a[2*k], wr_cyc_a[2*k+1]}, {21*k+20, 21*k+21});
        end
    endtask

    task automatic do_run(input int n, input logic dec, input logic cbc, input logic [63:0] ivv);
        model(n, dec, cbc, ivv);
        launch(n, dec, cbc, ivv);
        run_to(21*n+2);
        check_run(n);
    endtask

    initial begin
        logic [63:0] ivr;
        int n;
        reset = 1'b1; start = 1'b0; abort = 1'b0; decrypt = 1'b0; cbc_en = 1'b0;
        iv = 64'd0; num_blocks = '0; t0 = 0; rel = 0; exp_dec = 1'b0;
        clear_log();
        for (int i = 0; i < 512; i++) in_mem[i] = $urandom;
        repeat (3) @(negedge ok_clk);
        check("rst_core_in", core_in, 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_misc", {rd_addr, wr_en, wr_addr, core_round, core_decrypt,
                           busy, done, error, blocks_done}, 64'd0);
        reset = 1'b0;

        // ECB encrypt one block, then decrypt it back
        orig_blk[0] = {in_mem[1], in_mem[0]};
        do_run(1, 1'b0, 1'b0, 64'd0);
        in_mem[0] = out_mem[0]; in_mem[1] = out_mem[1];
        do_run(1, 1'b1, 1'b0, 64'd0);
        check("ecb_roundtrip", {out_mem[1], out_mem[0]}, orig_blk[0]);

        // CBC encrypt three blocks, then decrypt them back
        for (int k = 0; k < 3; k++) orig_blk[k] = {in_mem[2*k+1], in_mem[2*k]};
        do_run(3, 1'b0, 1'b1, IV_FIXED);
        for (int i = 0; i < 6; i++) in_mem[i] = out_mem[i];
        do_run(3, 1'b1, 1'b1, IV_FIXED);
        for (int k = 0; k < 3; k++)
            check("cbc_roundtrip", {out_mem[2*k+1], out_mem[2*k]}, orig_blk[k]);

        // Random lengths, modes and data
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 512; i++) in_mem[i] = $urandom;
            n = $urandom_range(6, 2);
            do_run(n, 1'($urandom), 1'($urandom), {$urandom, $urandom});
        end

        // Illegal lengths
        launch(0, 1'b0, 1'b0, 64'd0);
        run_to(4);
        check("err0_count", err_cnt, 1);
        check("err0_cycle", err_cyc, 1);
        check("err0_busy", busy_cnt, 0);
        check("err0_writes", wr_cnt, 0);
        launch(257, 1'b0, 1'b1, 64'd0);
        run_to(4);
        check("err257_count", err_cnt, 1);
        check("err257_cycle", err_cyc, 1);
        check("err257_busy", busy_cnt, 0);
        check("err257_writes", wr_cnt, 0);

        // Abort in the second block
        launch(4, 1'b0, 1'b0, 64'd0);
        run_to(30);
        abort = 1'b1;
        tick();
        check("abort_busy", busy, 64'd0);
        abort = 1'b0;
        run_to(40);
        check("abort_done", done_cnt, 0);
        check("abort_writes", wr_cnt, 2);
        check("abort_last_wr", last_wr_cyc, 21);
        check("abort_blocks_done", blocks_done, 1);

        // Reset mid-run
        launch(2, 1'b1, 1'b1, 64'hFFFF_0000_1234_5678);
        run_to(25);
        reset = 1'b1;
        tick();
        check("mrst_core_in", core_in, 64'd0);
        check("mrst_wr_data", wr_data, 64'd0);
        check("mrst_misc", {rd_addr, wr_en, wr_addr, core_round, core_decrypt,
                            busy, done, error, blocks_done}, 64'd0);
        reset = 1'b0;

        // Full depth with a start issued while busy
        for (int i = 0; i < 512; i++) in_mem[i] = $urandom;
        ivr = {$urandom, $urandom};
        model(256, 1'b0, 1'b1, ivr);
        launch(256, 1'b0, 1'b1, ivr);
        run_to(100);
        num_blocks = 9'd1;
        decrypt    = 1'b1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        run_to(21*256+2);
        check_run(256);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
